// File: rtl/csr_defs.sv
// rtl/csr_defs.sv - shared CSR numbers, field positions and exception codes
package csr_defs;

    localparam logic [13:0] CSR_CRMD   = 14'h0000;
    localparam logic [13:0] CSR_PRMD   = 14'h0001;
    localparam logic [13:0] CSR_ECFG   = 14'h0004;
    localparam logic [13:0] CSR_ESTAT  = 14'h0005;
    localparam logic [13:0] CSR_ERA    = 14'h0006;
    localparam logic [13:0] CSR_EENTRY = 14'h000C;
    localparam logic [13:0] CSR_SAVE0  = 14'h0030;
    localparam logic [13:0] CSR_SAVE1  = 14'h0031;
    localparam logic [13:0] CSR_SAVE2  = 14'h0032;
    localparam logic [13:0] CSR_SAVE3  = 14'h0033;
    localparam logic [13:0] CSR_TID    = 14'h0040;
    localparam logic [13:0] CSR_TCFG   = 14'h0041;
    localparam logic [13:0] CSR_TVAL   = 14'h0042;
    localparam logic [13:0] CSR_TICLR  = 14'h0044;

    localparam int CRMD_IE_BIT      = 2;
    localparam int ESTAT_ECODE_LSB  = 16;
    localparam int ESTAT_ESUB_LSB   = 22;
    localparam int ESTAT_IS_TI_BIT  = 11;
    localparam int TCFG_EN_BIT      = 0;
    localparam int TCFG_PERIODIC_BIT = 1;

    localparam logic [5:0]  ECODE_SYS = 6'h0B;
    localparam logic [5:0]  ECODE_INT = 6'h00;

    // LIE bit 10 has no interrupt source behind it, so it stays read-as-zero
    localparam logic [12:0] LIE_WMASK = 13'h1BFF;

    function automatic logic [31:0] apply_wmask(input logic [31:0] old_v,
                                                input logic [31:0] mask,
                                                input logic [31:0] new_v);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

endpackage

// File: rtl/csr_unit_if.sv
// rtl/csr_unit_if.sv - pipeline-to-CSR bundle: access port, commit events, interrupt lines
interface csr_unit_if;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic        ertn_flush;
    logic [7:0]  hw_int_in;
    logic [31:0] ex_entry;
    logic [31:0] ertn_pc;
    logic        has_int;

    modport master (
        output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
        output wb_ex, wb_ecode, wb_esubcode, wb_pc, ertn_flush, hw_int_in,
        input  csr_rvalue, ex_entry, ertn_pc, has_int
    );

    modport slave (
        input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
        input  wb_ex, wb_ecode, wb_esubcode, wb_pc, ertn_flush, hw_int_in,
        output csr_rvalue, ex_entry, ertn_pc, has_int
    );
endinterface

// File: rtl/csr_timer.sv
// rtl/csr_timer.sv - countdown timer holding TVAL and the enable, pulses on expiry
module csr_timer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_tcfg_we,
    input  logic        i_new_en,
    input  logic [29:0] i_new_initval,
    input  logic        i_periodic,
    input  logic [29:0] i_initval,
    output logic [31:0] o_tval,
    output logic        o_timer_fire
);
    logic [31:0] r_tval;
    logic        r_en;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tval <= '0;
            r_en   <= 1'b0;
        end else if (i_tcfg_we) begin
            r_en   <= i_new_en;
            r_tval <= {i_new_initval, 2'b00};
        end else if (r_en) begin
            if (r_tval != '0)
                r_tval <= r_tval - 32'd1;
            else if (i_periodic)
                r_tval <= {i_initval, 2'b00};
            else
                r_en <= 1'b0;
        end
    end

    // A TCFG write in the expiry cycle re-arms instead of firing
    assign o_timer_fire = r_en && (r_tval == '0) && !i_tcfg_we;
    assign o_tval       = r_tval;
endmodule

// File: rtl/csr_unit.sv
// rtl/csr_unit.sv - exception/interrupt/timer control and status register file
module csr_unit
    import csr_defs::*;
#(
    parameter logic [31:0] TID_RESET = 32'h0
) (
    input  logic      clk,
    input  logic      resetn,
    csr_unit_if.slave bus
);
    logic [1:0]  r_crmd_plv;
    logic        r_crmd_ie;
    logic        r_crmd_da;
    logic [1:0]  r_prmd_pplv;
    logic        r_prmd_pie;
    logic [12:0] r_ecfg_lie;
    logic [1:0]  r_is_sw;
    logic [7:0]  r_is_hw;
    logic        r_is_ti;
    logic [5:0]  r_ecode;
    logic [8:0]  r_esubcode;
    logic [31:0] r_era;
    logic [25:0] r_eentry;
    logic [31:0] r_save [4];
    logic [31:0] r_tid;
    logic [31:0] r_tcfg;

    logic [31:0] w_crmd, w_prmd, w_ecfg, w_estat, w_cur, w_new, w_tval;
    logic        w_wr, w_tcfg_we, w_ticlr, w_timer_fire;

    assign w_crmd  = {28'b0, r_crmd_da, r_crmd_ie, r_crmd_plv};
    assign w_prmd  = {29'b0, r_prmd_pie, r_prmd_pplv};
    assign w_ecfg  = {19'b0, r_ecfg_lie};
    assign w_estat = {1'b0, r_esubcode, r_ecode, 3'b0, 1'b0, r_is_ti, 1'b0, r_is_hw, r_is_sw};

    always_comb begin
        w_cur = '0;
        case (bus.csr_num)
            CSR_CRMD:   w_cur = w_crmd;
            CSR_PRMD:   w_cur = w_prmd;
            CSR_ECFG:   w_cur = w_ecfg;
            CSR_ESTAT:  w_cur = w_estat;
            CSR_ERA:    w_cur = r_era;
            CSR_EENTRY: w_cur = {r_eentry, 6'b0};
            CSR_SAVE0:  w_cur = r_save[0];
            CSR_SAVE1:  w_cur = r_save[1];
            CSR_SAVE2:  w_cur = r_save[2];
            CSR_SAVE3:  w_cur = r_save[3];
            CSR_TID:    w_cur = r_tid;
            CSR_TCFG:   w_cur = r_tcfg;
            CSR_TVAL:   w_cur = w_tval;
            default:    w_cur = '0;
        endcase
    end

    // Only the field slices below are stored, so non-writable bits can never change
    assign w_new     = apply_wmask(w_cur, bus.csr_wmask, bus.csr_wvalue);
    assign w_wr      = bus.csr_we && !bus.wb_ex && !bus.ertn_flush;
    assign w_tcfg_we = w_wr && (bus.csr_num == CSR_TCFG);
    assign w_ticlr   = w_wr && (bus.csr_num == CSR_TICLR) && bus.csr_wmask[0] && bus.csr_wvalue[0];

    csr_timer u_timer (
        .clk           (clk),
        .resetn        (resetn),
        .i_tcfg_we     (w_tcfg_we),
        .i_new_en      (w_new[TCFG_EN_BIT]),
        .i_new_initval (w_new[31:2]),
        .i_periodic    (r_tcfg[TCFG_PERIODIC_BIT]),
        .i_initval     (r_tcfg[31:2]),
        .o_tval        (w_tval),
        .o_timer_fire  (w_timer_fire)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_crmd_plv  <= '0;
            r_crmd_ie   <= 1'b0;
            r_crmd_da   <= 1'b1;
            r_prmd_pplv <= '0;
            r_prmd_pie  <= 1'b0;
            r_ecfg_lie  <= '0;
            r_is_sw     <= '0;
            r_is_hw     <= '0;
            r_is_ti     <= 1'b0;
            r_ecode     <= '0;
            r_esubcode  <= '0;
            r_era       <= '0;
            r_eentry    <= '0;
            for (int k = 0; k < 4; k++) r_save[k] <= '0;
            r_tid       <= TID_RESET;
            r_tcfg      <= '0;
        end else begin
            r_is_hw <= bus.hw_int_in;
            if (w_timer_fire)
                r_is_ti <= 1'b1;
            else if (w_ticlr)
                r_is_ti <= 1'b0;

            if (bus.wb_ex) begin
                r_prmd_pplv <= r_crmd_plv;
                r_prmd_pie  <= r_crmd_ie;
                r_crmd_plv  <= '0;
                r_crmd_ie   <= 1'b0;
                r_era       <= bus.wb_pc;
                r_ecode     <= bus.wb_ecode;
                r_esubcode  <= bus.wb_esubcode;
            end else if (bus.ertn_flush) begin
                r_crmd_plv <= r_prmd_pplv;
                r_crmd_ie  <= r_prmd_pie;
            end else if (w_wr) begin
                case (bus.csr_num)
                    CSR_CRMD: begin
                        r_crmd_plv <= w_new[1:0];
                        r_crmd_ie  <= w_new[CRMD_IE_BIT];
                        r_crmd_da  <= w_new[3];
                    end
                    CSR_PRMD: begin
                        r_prmd_pplv <= w_new[1:0];
                        r_prmd_pie  <= w_new[2];
                    end
                    CSR_ECFG:   r_ecfg_lie <= w_new[12:0] & LIE_WMASK;
                    CSR_ESTAT:  r_is_sw    <= w_new[1:0];
                    CSR_ERA:    r_era      <= w_new;
                    CSR_EENTRY: r_eentry   <= w_new[31:6];
                    CSR_SAVE0:  r_save[0]  <= w_new;
                    CSR_SAVE1:  r_save[1]  <= w_new;
                    CSR_SAVE2:  r_save[2]  <= w_new;
                    CSR_SAVE3:  r_save[3]  <= w_new;
                    CSR_TID:    r_tid      <= w_new;
                    CSR_TCFG:   r_tcfg     <= w_new;
                    default: ;
                endcase
            end
        end
    end

    assign bus.csr_rvalue = bus.csr_re ? w_cur : 32'h0;
    assign bus.has_int    = r_crmd_ie && ((w_estat[12:0] & r_ecfg_lie) != '0);
    assign bus.ex_entry   = {r_eentry, 6'b0};
    assign bus.ertn_pc    = r_era;
endmodule

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 Parameter TID_RESET, default 32'h0, reset value of TID.
REQ-002 Reset is resetn, synchronous, active-low; clock is clk.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 resetn  in  1  synchronous active-low reset.
REQ-005 csr_re  in  1  read enable; csr_num  in  14  read/write address.
REQ-006 csr_rvalue  out  32  combinational read data.
REQ-007 csr_we  in  1  write enable; csr_wmask  in  32  bit mask; csr_wvalue  in  32  write data.
REQ-008 wb_ex  in  1  exception commit; wb_ecode  in  6; wb_esubcode  in  9; wb_pc  in  32  faulting PC.
REQ-009 ertn_flush  in  1  ertn commit.
REQ-010 hw_int_in  in  8  external interrupt lines, level-sensitive.
REQ-011 ex_entry  out  32  EENTRY value; ertn_pc  out  32  ERA value.
REQ-012 has_int  out  1  pending enabled interrupt.

Function
REQ-013 Implemented CSRs: CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, EENTRY 0xC, SAVE0-3 0x30-0x33, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44.
REQ-014 Read of an unimplemented number, or csr_re=0, returns 32'h0; reads reflect state before the current edge (no bypass).
REQ-015 Write: writable field bits update as (old & ~wmask) | (wvalue & wmask); non-writable bits unchanged.
REQ-016 Writable fields: CRMD[3:0] (PLV[1:0], IE[2], DA[3]); PRMD[2:0] (PPLV, PIE); ECFG.LIE[12:0] except bit 10; ESTAT.IS[1:0]; ERA[31:0]; EENTRY[31:6]; SAVE0-3[31:0]; TID[31:0]; TCFG[31:0]; TVAL read-only; TICLR reads 0.
REQ-017 Priority per cycle: wb_ex > ertn_flush > csr_we; lower-priority event is ignored that cycle.
REQ-018 On wb_ex: PRMD.PPLV<=CRMD.PLV, PRMD.PIE<=CRMD.IE, CRMD.PLV<=0, CRMD.IE<=0, ERA<=wb_pc, ESTAT.Ecode[21:16]<=wb_ecode, ESTAT.EsubCode[30:22]<=wb_esubcode.
REQ-019 On ertn_flush: CRMD.PLV<=PRMD.PPLV, CRMD.IE<=PRMD.PIE; PRMD unchanged.
REQ-020 ESTAT.IS[9:2] <= hw_int_in every cycle; IS[12] and IS[10] read 0.
REQ-021 Timer: internal timer_en. Write to TCFG sets timer_en<=new TCFG.En and TVAL<={new InitVal[31:2],2'b00}.
REQ-022 Else if timer_en and TVAL!=0: TVAL<=TVAL-1.
REQ-023 Else if timer_en and TVAL==0: ESTAT.IS[11]<=1; if TCFG.Periodic TVAL<={InitVal,2'b00} else timer_en<=0.
REQ-024 TICLR write with wmask[0]&wvalue[0] clears IS[11]; a same-cycle timer set wins over the clear.
REQ-025 has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]); combinational.
REQ-026 ex_entry = {EENTRY[31:6],6'b0}; ertn_pc = ERA; both combinational.
REQ-027 Writes to ESTAT Ecode/EsubCode/IS[12:2] are ignored; only exception entry updates Ecode/EsubCode.

Reset
REQ-028 On resetn=0: CRMD=32'h8 (DA=1), PRMD=0, ECFG=0, ESTAT=0, ERA=0, EENTRY=0, SAVE0-3=0, TID=TID_RESET, TCFG=0, TVAL=0, timer_en=0.
REQ-029 Reset takes priority over wb_ex, ertn_flush and writes in the same cycle; has_int=0 the cycle after reset asserts.

Structure
REQ-030 Shared package csr_defs: CSR number constants, field bit positions, ecode constants (SYS=6'h0B, INT=6'h00).
REQ-031 One sub-module csr_timer: holds TVAL and timer_en, outputs timer_fire pulse to csr_unit.

Verification
REQ-032 Write CRMD wvalue=32'h7, wmask=32'h4 from reset -> read CRMD = 32'hC.
REQ-033 CRMD=32'h7; wb_ex=1, ecode=6'h0B, wb_pc=32'h1C000100 -> next cycle CRMD=32'h0, PRMD=32'h7, ERA=32'h1C000100, ESTAT[21:16]=6'h0B; then ertn_flush -> CRMD PLV=3, IE=1.
REQ-034 wb_ex and csr_we to SAVE0 (wvalue 32'h55) same cycle -> SAVE0 unchanged, exception state updated.
REQ-035 TCFG write 32'h0000000B (En=1, Periodic=1, InitVal=2) -> TVAL=8, counts 7..0, IS[11]=1 on the cycle after TVAL=0, TVAL reloads 8; TICLR write 1 clears IS[11].
REQ-036 ECFG.LIE[11]=1, CRMD.IE=1, timer fires -> has_int=1; CRMD.IE=0 -> has_int=0; hw_int_in=8'h01 with LIE[2]=1, IE=1 -> has_int=1.
